// File: rtl/ghash_input_formatter.sv
// GHASH input formatter: pads and packs 128b blocks into N_BLOCKS-wide words,
// then appends the len(A)||len(C) block for the GHASH core.
module ghash_input_formatter #(
   parameter int unsigned NB_BLOCK      = 128,
   parameter int unsigned N_BLOCKS      = 2,
   parameter int unsigned LOG2_N_BLOCKS = 1,
   parameter int unsigned NB_DATA       = N_BLOCKS * NB_BLOCK
) (
   input  logic                i_clock,
   input  logic                i_reset_n,
   input  logic                i_start,
   input  logic                i_valid,
   output logic                o_ready,
   input  logic [NB_BLOCK-1:0] i_block,
   input  logic [4:0]          i_bytes,
   input  logic                i_is_aad,
   input  logic                i_eom,
   output logic [NB_DATA-1:0]  o_data_x_bus,
   output logic                o_valid,
   output logic                o_sop,
   output logic [N_BLOCKS-1:0] o_skip_bus,
   output logic                o_eop,
   output logic                o_err
);

   localparam int unsigned NB_BYTES = NB_BLOCK / 8;
   localparam int unsigned NB_CNT   = 64;
   localparam logic [LOG2_N_BLOCKS-1:0] LAST_LANE = LOG2_N_BLOCKS'(N_BLOCKS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_LEN
   } state_t;

   state_t                   state, nxt_state;
   logic [LOG2_N_BLOCKS-1:0] ptr, nxt_ptr, len_lane;
   logic [NB_DATA-1:0]       pbuf, nxt_buf, nxt_data;
   logic [NB_CNT-1:0]        aad_bits, ct_bits, nxt_aad, nxt_ct;
   logic                     sop_pend, nxt_sop_pend;
   logic                     aad_phase, nxt_aad_phase;
   logic                     nxt_ready, nxt_valid, nxt_sop, nxt_eop, nxt_err;
   logic [N_BLOCKS-1:0]      nxt_skip;
   logic                     emit;
   logic [NB_BLOCK-1:0]      len_blk;

   // Saturated byte count, bit count and zero-padded block
   logic [4:0]          bytes_sat;
   logic [7:0]          blk_bits;
   logic [NB_BLOCK-1:0] keep_mask, masked;

   always_comb begin
      bytes_sat = (i_bytes > 5'(NB_BYTES)) ? 5'(NB_BYTES) : i_bytes;
      blk_bits  = {bytes_sat, 3'b000};
      keep_mask = (bytes_sat >= 5'(NB_BYTES)) ? {NB_BLOCK{1'b1}}
                                              : ~({NB_BLOCK{1'b1}} >> blk_bits);
      masked    = i_block & keep_mask;
   end

   // Next-state, packing and output decode
   always_comb begin
      nxt_state     = state;
      nxt_ptr       = ptr;
      nxt_buf       = pbuf;
      nxt_aad       = aad_bits;
      nxt_ct        = ct_bits;
      nxt_sop_pend  = sop_pend;
      nxt_aad_phase = aad_phase;
      nxt_data      = o_data_x_bus;
      nxt_valid     = 1'b0;
      nxt_sop       = 1'b0;
      nxt_eop       = 1'b0;
      nxt_err       = 1'b0;
      nxt_skip      = '0;
      emit          = 1'b0;
      len_lane      = ptr;
      len_blk       = '0;

      case (state)
         ST_IDLE: begin
            if (i_start) begin
               nxt_state     = ST_DATA;
               nxt_ptr       = '0;
               nxt_buf       = '0;
               nxt_aad       = '0;
               nxt_ct        = '0;
               nxt_sop_pend  = 1'b1;
               nxt_aad_phase = 1'b1;
            end
         end

         ST_DATA: begin
            if (i_valid) begin
               if ((i_is_aad && !aad_phase) || (bytes_sat == 5'd0 && !i_eom)) begin
                  nxt_err = 1'b1;
               end else begin
                  if (bytes_sat != 5'd0) begin
                     for (int unsigned k = 0; k < N_BLOCKS; k++) begin
                        if (LOG2_N_BLOCKS'(k) == ptr)
                           nxt_buf[k*NB_BLOCK +: NB_BLOCK] = masked;
                     end
                     if (i_is_aad) begin
                        nxt_aad = aad_bits + NB_CNT'(blk_bits);
                     end else begin
                        nxt_ct        = ct_bits + NB_CNT'(blk_bits);
                        nxt_aad_phase = 1'b0;
                     end
                     nxt_ptr = ptr + LOG2_N_BLOCKS'(1);
                  end
                  len_blk = {nxt_aad, nxt_ct};

                  if (bytes_sat != 5'd0 && ptr == LAST_LANE) begin
                     // word filled: emit it; length follows from LEN if this was eom
                     emit     = 1'b1;
                     nxt_data = nxt_buf;
                     if (i_eom)
                        nxt_state = ST_LEN;
                  end else if (i_eom) begin
                     // length fits in this word; lanes above it are skipped
                     emit     = 1'b1;
                     len_lane = nxt_ptr;
                     nxt_data = nxt_buf;
                     for (int unsigned k = 0; k < N_BLOCKS; k++) begin
                        if (LOG2_N_BLOCKS'(k) == len_lane) begin
                           nxt_data[k*NB_BLOCK +: NB_BLOCK] = len_blk;
                        end else if (LOG2_N_BLOCKS'(k) > len_lane) begin
                           nxt_data[k*NB_BLOCK +: NB_BLOCK] = '0;
                           nxt_skip[k]                      = 1'b1;
                        end
                     end
                     nxt_eop   = 1'b1;
                     nxt_state = ST_IDLE;
                  end
               end
            end
         end

         ST_LEN: begin
            emit                     = 1'b1;
            nxt_data                 = '0;
            nxt_data[NB_BLOCK-1:0]   = {aad_bits, ct_bits};
            nxt_skip                 = ~N_BLOCKS'(1);
            nxt_eop                  = 1'b1;
            nxt_state                = ST_IDLE;
         end

         default: nxt_state = ST_IDLE;
      endcase

      if (emit) begin
         nxt_valid    = 1'b1;
         nxt_sop      = sop_pend;
         nxt_sop_pend = 1'b0;
      end
      nxt_ready = (nxt_state == ST_DATA);
   end

   // State, datapath and registered outputs
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         state        <= ST_IDLE;
         ptr          <= '0;
         pbuf         <= '0;
         aad_bits     <= '0;
         ct_bits      <= '0;
         sop_pend     <= 1'b0;
         aad_phase    <= 1'b0;
         o_ready      <= 1'b0;
         o_valid      <= 1'b0;
         o_sop        <= 1'b0;
         o_eop        <= 1'b0;
         o_err        <= 1'b0;
         o_skip_bus   <= '0;
         o_data_x_bus <= '0;
      end else begin
         state        <= nxt_state;
         ptr          <= nxt_ptr;
         pbuf         <= nxt_buf;
         aad_bits     <= nxt_aad;
         ct_bits      <= nxt_ct;
         sop_pend     <= nxt_sop_pend;
         aad_phase    <= nxt_aad_phase;
         o_ready      <= nxt_ready;
         o_valid      <= nxt_valid;
         o_sop        <= nxt_sop;
         o_eop        <= nxt_eop;
         o_err        <= nxt_err;
         o_skip_bus   <= nxt_skip;
         o_data_x_bus <= nxt_data;
      end
   end

endmodule

// File: tb/tb_ghash_input_formatter.sv
// Self-checking bench for ghash_input_formatter (N_BLOCKS=2 and N_BLOCKS=4).
module tb_ghash_input_formatter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, start, start4, valid, is_aad, eom;
   logic [127:0] blk;
   logic [4:0]   bytes;

   logic         ready2, valid2, sop2, eop2, err2;
   logic [255:0] data2;
   logic [1:0]   skip2;
   logic         ready4, valid4, sop4, eop4, err4;
   logic [511:0] data4;
   logic [3:0]   skip4;

   ghash_input_formatter #(.NB_BLOCK(128), .N_BLOCKS(2), .LOG2_N_BLOCKS(1)) u2 (
      .i_clock(clk), .i_reset_n(rst_n), .i_start(start), .i_valid(valid), .o_ready(ready2),
      .i_block(blk), .i_bytes(bytes), .i_is_aad(is_aad), .i_eom(eom),
      .o_data_x_bus(data2), .o_valid(valid2), .o_sop(sop2), .o_skip_bus(skip2),
      .o_eop(eop2), .o_err(err2));

   ghash_input_formatter #(.NB_BLOCK(128), .N_BLOCKS(4), .LOG2_N_BLOCKS(2)) u4 (
      .i_clock(clk), .i_reset_n(rst_n), .i_start(start4), .i_valid(valid), .o_ready(ready4),
      .i_block(blk), .i_bytes(bytes), .i_is_aad(is_aad), .i_eom(eom),
      .o_data_x_bus(data4), .o_valid(valid4), .o_sop(sop4), .o_skip_bus(skip4),
      .o_eop(eop4), .o_err(err4));

   typedef struct {logic [255:0] data; logic [1:0] skip; logic sop; logic eop;} exp2_t;
   typedef struct {logic [511:0] data; logic [3:0] skip; logic sop; logic eop;} exp4_t;

   exp2_t q2[$];
   exp4_t q4[$];
   int    n_checks = 0;
   int    n_fails  = 0;
   int    err_cnt2 = 0;

   // Bytes 0..nb-1 (MSB first) kept, the rest zero
   function automatic logic [127:0] keep(input logic [127:0] b, input int nb);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++)
         if (i < nb) r[127-8*i -: 8] = b[127-8*i -: 8];
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Scoreboard for the 2-lane instance: compare every emitted word
   always @(negedge clk) begin : mon2
      exp2_t        e;
      logic [255:0] care;
      if (rst_n) begin
         if (err2) err_cnt2++;
         if (valid2) begin
            n_checks++;
            if (q2.size() == 0) begin
               n_fails++;
               $display("FAIL unexpected_word2 got data=%h skip=%b, required no word", data2, skip2);
            end else begin
               e = q2.pop_front();
               care = '0;
               for (int k = 0; k < 2; k++) if (!e.skip[k]) care[k*128 +: 128] = '1;
               if ((data2 & care) !== (e.data & care) || skip2 !== e.skip ||
                   sop2 !== e.sop || eop2 !== e.eop) begin
                  n_fails++;
                  $display("FAIL word2 got data=%h skip=%b sop=%b eop=%b, required data=%h skip=%b sop=%b eop=%b",
                           data2, skip2, sop2, eop2, e.data, e.skip, e.sop, e.eop);
               end
            end
         end else begin
            n_checks++;
            if ({skip2, sop2, eop2} !== 4'b0000) begin
               n_fails++;
               $display("FAIL idle_flags2 got skip=%b sop=%b eop=%b, required 0", skip2, sop2, eop2);
            end
         end
      end
   end

   // Scoreboard for the 4-lane instance
   always @(negedge clk) begin : mon4
      exp4_t e;
      if (rst_n && valid4) begin
         n_checks++;
         if (q4.size() == 0) begin
            n_fails++;
            $display("FAIL unexpected_word4 got data=%h, required no word", data4);
         end else begin
            e = q4.pop_front();
            if (data4 !== e.data || skip4 !== e.skip || sop4 !== e.sop || eop4 !== e.eop) begin
               n_fails++;
               $display("FAIL word4 got data=%h skip=%b sop=%b eop=%b, required data=%h skip=%b sop=%b eop=%b",
                        data4, skip4, sop4, eop4, e.data, e.skip, e.sop, e.eop);
            end
         end
      end
   end

   task automatic push2(input logic [255:0] d, input logic [1:0] s, input logic sp, input logic ep);
      exp2_t e;
      e.data = d; e.skip = s; e.sop = sp; e.eop = ep;
      q2.push_back(e);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic [127:0] b, input int nb, input logic aad, input logic e);
      valid = 1'b1; blk = b; bytes = 5'(nb); is_aad = aad; eom = e;
      @(negedge clk);
      valid = 1'b0; eom = 1'b0;
   endtask

   task automatic drain(input string name);
      repeat (3) @(negedge clk);
      n_checks++;
      if (q2.size() != 0 || q4.size() != 0) begin
         n_fails++;
         $display("FAIL %s_drain got %0d/%0d words outstanding, required 0", name, q2.size(), q4.size());
      end
   endtask

   task automatic check_zero(input string name);
      n_checks++;
      if ({ready2, valid2, sop2, eop2, err2, skip2, data2} !== '0 ||
          {ready4, valid4, sop4, eop4, err4, skip4, data4} !== '0) begin
         n_fails++;
         $display("FAIL %s got ready=%b valid=%b sop=%b eop=%b err=%b skip=%b, required all 0",
                  name, ready2, valid2, sop2, eop2, err2, skip2);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_zero("reset_outputs");
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_aad_ct();
      logic [127:0] a, c;
      a = rnd128(); c = rnd128();
      push2({c, a}, 2'b00, 1'b1, 1'b0);
      push2({128'h0, 64'd128, 64'd128}, 2'b10, 1'b0, 1'b1);
      do_start();
      n_checks++;
      if (ready2 !== 1'b1) begin
         n_fails++; $display("FAIL ready_data got %b, required 1", ready2);
      end
      send(a, 16, 1'b1, 1'b0);
      send(c, 16, 1'b0, 1'b1);
      n_checks++;
      if (ready2 !== 1'b0) begin
         n_fails++; $display("FAIL ready_len got %b, required 0", ready2);
      end
      drain("aad_ct");
   endtask

   task automatic test_partial();
      logic [127:0] c0, c1, c2;
      c0 = rnd128(); c1 = rnd128(); c2 = rnd128();
      push2({c1, c0}, 2'b00, 1'b1, 1'b0);
      push2({64'd0, 64'd296, c2[127:88], 88'h0}, 2'b00, 1'b0, 1'b1);
      do_start();
      send(c0, 16, 1'b0, 1'b0);
      send(c1, 16, 1'b0, 1'b0);
      send(c2, 5, 1'b0, 1'b1);
      drain("partial");
   endtask

   task automatic test_empty();
      push2({128'h0, 128'h0}, 2'b10, 1'b1, 1'b1);
      do_start();
      send(rnd128(), 0, 1'b0, 1'b1);
      drain("empty");
   endtask

   task automatic test_aad_after_ct();
      logic [127:0] c0, c1;
      int           err0;
      c0 = rnd128(); c1 = rnd128();
      err0 = err_cnt2;
      push2({c1, c0}, 2'b00, 1'b1, 1'b0);
      push2({128'h0, 64'd0, 64'd256}, 2'b10, 1'b0, 1'b1);
      do_start();
      send(c0, 16, 1'b0, 1'b0);
      send(rnd128(), 16, 1'b1, 1'b0);
      n_checks++;
      if (err2 !== 1'b1) begin
         n_fails++; $display("FAIL err_pulse got %b, required 1", err2);
      end
      send(c1, 16, 1'b0, 1'b1);
      drain("aad_after_ct");
      n_checks++;
      if (err_cnt2 - err0 != 1) begin
         n_fails++; $display("FAIL err_count got %0d, required 1", err_cnt2 - err0);
      end
   endtask

   task automatic test_reset_mid();
      logic [127:0] c;
      c = rnd128();
      do_start();
      send(rnd128(), 16, 1'b0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      check_zero("reset_mid_outputs");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (valid2 !== 1'b0 || ready2 !== 1'b0) begin
         n_fails++; $display("FAIL reset_mid_idle got valid=%b ready=%b, required 0 0", valid2, ready2);
      end
      push2({64'd0, 64'd128, c}, 2'b00, 1'b1, 1'b1);
      do_start();
      send(c, 16, 1'b0, 1'b1);
      drain("reset_mid");
   endtask

   task automatic test_n4();
      logic [127:0] a0, a1, c;
      exp4_t        e;
      a0 = rnd128(); a1 = rnd128(); c = rnd128();
      e.data = {64'd160, 64'd128, c, keep(a1, 4), a0};
      e.skip = 4'b0000; e.sop = 1'b1; e.eop = 1'b1;
      q4.push_back(e);
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      send(a0, 16, 1'b1, 1'b0);
      send(a1, 4, 1'b1, 1'b0);
      send(c, 16, 1'b0, 1'b1);
      drain("n4");
   endtask

   // Random messages, each started as soon as the formatter is back in IDLE
   task automatic test_back_to_back();
      for (int m = 0; m < 8; m++) begin
         int           na, nc, tot, nb, eff, ptr;
         logic [255:0] w;
         logic [63:0]  ab, cb;
         logic         sop, wrapped, aad, last;
         logic [127:0] b;
         na = $urandom_range(0, 2); nc = $urandom_range(0, 3);
         if (na + nc == 0) nc = 1;
         tot = na + nc; ptr = 0; w = '0; ab = '0; cb = '0; sop = 1'b1; wrapped = 1'b0;
         do_start();
         for (int i = 0; i < tot; i++) begin
            aad  = (i < na);
            last = (i == tot - 1);
            nb   = last ? $urandom_range(0, 20) : $urandom_range(1, 20);
            eff  = (nb > 16) ? 16 : nb;
            b    = rnd128();
            wrapped = 1'b0;
            if (eff > 0) begin
               w[ptr*128 +: 128] = keep(b, eff);
               if (aad) ab = ab + 64'(8 * eff); else cb = cb + 64'(8 * eff);
               ptr++;
               if (ptr == 2) begin
                  push2(w, 2'b00, sop, 1'b0);
                  sop = 1'b0; ptr = 0; wrapped = 1'b1;
               end
            end
            if (last) begin
               if (wrapped) begin
                  push2({128'h0, ab, cb}, 2'b10, 1'b0, 1'b1);
               end else begin
                  w[ptr*128 +: 128] = {ab, cb};
                  push2(w, (ptr == 0) ? 2'b10 : 2'b00, sop, 1'b1);
               end
            end
            send(b, nb, aad, last);
         end
         if (wrapped) @(negedge clk);
      end
      drain("back_to_back");
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; start4 = 1'b0; valid = 1'b0;
      blk = '0; bytes = '0; is_aad = 1'b0; eom = 1'b0;
      @(negedge clk);
      test_reset();
      test_aad_ct();
      test_partial();
      test_empty();
      test_aad_after_ct();
      test_reset_mid();
      test_n4();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
